// File: rtl/proc.sv
// Single-cycle 4-bit demo core running a fixed Fibonacci program from internal ROM.
// Optional per-cycle trace printout is compiled in when PROC_TRACE_EN is defined.
module proc (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] pc,
  output logic [3:0] result
);

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_LI  = 2'b01,
    OP_ADD = 2'b10,
    OP_JMP = 2'b11
  } op_e;

  logic [3:0] pc_q, pc_d;
  logic [3:0] result_q, result_d;
  logic [3:0] rf_q [4];
  logic [3:0] rf_d [4];

  logic [7:0] instr;
  op_e        op;
  logic [1:0] rd, rs1, rs2;
  logic [3:0] imm;
  logic [3:0] rs1_val, rs2_val;

  always_comb begin
    case (pc_q)
      4'd0:    instr = 8'h50;  // li  r1,0
      4'd1:    instr = 8'h61;  // li  r2,1
      4'd2:    instr = 8'h9A;  // add r1,r2,r2
      4'd3:    instr = 8'hA6;  // add r2,r1,r2
      4'd4:    instr = 8'h96;  // add r1,r1,r2
      4'd5:    instr = 8'hA6;
      4'd6:    instr = 8'h96;
      4'd7:    instr = 8'hA6;
      4'd8:    instr = 8'hC8;  // jmp 8
      default: instr = 8'h00;
    endcase
  end

  assign op  = op_e'(instr[7:6]);
  assign rd  = instr[5:4];
  assign rs1 = instr[3:2];
  assign rs2 = instr[1:0];
  assign imm = instr[3:0];

  assign rs1_val = (rs1 == 2'd0) ? 4'd0 : rf_q[rs1];
  assign rs2_val = (rs2 == 2'd0) ? 4'd0 : rf_q[rs2];

  always_comb begin
    pc_d     = pc_q + 4'd1;
    result_d = result_q;
    rf_d     = rf_q;
    case (op)
      OP_LI: begin
        rf_d[rd] = imm;
        result_d = imm;
      end
      OP_ADD: begin
        rf_d[rd] = rs1_val + rs2_val;
        result_d = rs1_val + rs2_val;
      end
      OP_JMP:  pc_d = imm;
      default: ;
    endcase
    // r0 is hardwired; a write to it only lands on result
    rf_d[0] = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= 4'd0;
      result_q <= 4'd0;
      for (int i = 0; i < 4; i++) rf_q[i] <= 4'd0;
    end else begin
      pc_q     <= pc_d;
      result_q <= result_d;
      rf_q     <= rf_d;
    end
  end

`ifdef PROC_TRACE_EN
  always @(posedge clk) begin
    if (!reset)
      $display("proc trace: pc=%0d instr=%02h op=%s result=%0d",
               pc_q, instr, op.name(), result_q);
  end
`endif

  assign pc     = pc_q;
  assign result = result_q;

endmodule

// File: tb/tb_proc.sv
// Directed bench for proc: reset behaviour, Fibonacci trace, jmp-8 hold and mid-run resets.
module tb_proc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pc;
  logic [3:0] result;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] exp_pc  [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
  logic [3:0] exp_res [9] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13, 4'd5};

  proc dut (
    .clk    (clk),
    .reset  (reset),
    .pc     (pc),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] p, input logic [3:0] r);
    vectors++;
    assert (pc === p) else begin
      miscompares++;
      $error("FAIL %s pc: observed %0h expected %0h", tag, pc, p);
    end
    assert (result === r) else begin
      miscompares++;
      $error("FAIL %s result: observed %0h expected %0h", tag, result, r);
    end
  endtask

  // From the first post-release cycle, step through the full trace and the jmp hold
  task automatic run_sequence(input string tag, input int hold_cycles);
    check({tag, "_c0"}, exp_pc[0], exp_res[0]);
    for (int i = 1; i < 9; i++) begin
      tick();
      check($sformatf("%s_c%0d", tag, i), exp_pc[i], exp_res[i]);
    end
    for (int i = 0; i < hold_cycles; i++) begin
      tick();
      check($sformatf("%s_hold%0d", tag, i), 4'd8, 4'd5);
    end
  endtask

  initial begin
    reset = 1'b1;
    tick();
    check("reset_1", 4'd0, 4'd0);
    tick();
    check("reset_2", 4'd0, 4'd0);
    reset = 1'b0;

    run_sequence("run1", 10);

    // single-cycle reset while pc=5
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("restart", 4'd0, 4'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("pre5_c%0d", i), exp_pc[i], exp_res[i]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_sequence("after_pc5", 3);

    // long reset from mid-run
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) tick();
    check("pre_long_c3", 4'd3, 4'd2);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("long_reset_%0d", i), 4'd0, 4'd0);
    end
    reset = 1'b0;
    run_sequence("after_long", 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/proc.md
# proc

Minimal single-cycle 4-bit processor that runs a fixed Fibonacci program from an internal ROM. It has no memory or I/O bus. It exposes its program counter and the most recent register write-back value, and is used as a self-contained demo core. One instruction retires per clock; there are no stalls.

## Interface
- No parameters. Data width 4 bits, PC width 4 bits and ROM depth 16 are fixed.
- `clk`  input  1  rising-edge clock; the only clock.
- `reset`  input  1  synchronous, active-high reset.
- `pc`  output  4  address of the instruction executing this cycle (registered).
- `result`  output  4  value written by the most recent register-writing instruction (registered).

## Operation
- State:
  - `pc` register.
  - Register file r0..r3, 4 bits each; r0 always reads 0 and ignores writes.
  - `result` register.
- ROM: 16 x 8-bit, combinational read at `pc`. Instruction fields:
  - op = [7:6].
  - rd = [5:4].
  - li: imm = [3:0].
  - add: rs1 = [3:2], rs2 = [1:0].
  - jmp: target = [3:0].
- Opcodes:
  - 00 nop: pc+1; no writes.
  - 01 li: rd <= imm; result <= imm; pc+1.
  - 10 add: rd <= (rs1 + rs2) mod 16; result <= same sum; pc+1. Carry is discarded.
  - 11 jmp: pc <= target; no register or result write.
- Reads see register values from before the current cycle's write. A write to r0 still updates `result`.
- Fixed ROM program:
  - 0: li r1,0
  - 1: li r2,1
  - 2: add r1,r2,r2
  - 3: add r2,r1,r2
  - 4: add r1,r1,r2
  - 5: add r2,r1,r2
  - 6: add r1,r1,r2
  - 7: add r2,r1,r2
  - 8: jmp 8
  - 9–15: nop
- PC arithmetic wraps 15→0. This is unreachable with the fixed program.

## Timing
- Reset: on any rising edge with `reset`=1, set pc=0, r1..r3=0 and result=0. Reset has priority over execution.
- `reset` held for N cycles: outputs stay pc=0, result=0 for all N.
- First cycle after reset release: pc=0, result=0. The instruction at 0 executes on that edge.
- Latency: an instruction at pc k shows its write value on `result` in the cycle where pc shows its successor.
- Expected trace, one line per cycle from reset release (pc/result): 0/0, 1/0, 2/1, 3/2, 4/3, 5/5, 6/8, 7/13, 8/5, then 8/5 forever.
- Mid-run reset: the next edge returns to pc=0/result=0 and the program restarts identically.
- Outputs are undefined before the first reset edge.

## Configuration
- `PROC_TRACE_EN`: when defined, the block prints one line per non-reset rising edge via `$display`. The line contains pc, raw instruction, decoded opcode and result.
- When undefined, no trace logic is compiled.
- Functional behaviour is identical either way.

## Test plan
- Reset for 2 cycles, then release -> pc=0, result=0 in the first cycle; no X on either output.
- Run 8 cycles after reset -> pc/result = 0/0, 1/0, 2/1, 3/2, 4/3, 5/5, 6/8, 7/13.
- Continue 10 more cycles -> pc stuck at 8, result=5 (21 mod 16), stable every cycle.
- Assert reset for 1 cycle while pc=5 -> next cycle 0/0; the full sequence then repeats exactly.
- Hold reset high for 5 cycles mid-run -> pc=0, result=0 throughout; normal sequence after release.
- Build with and without `PROC_TRACE_EN` -> identical pc/result traces; trace lines appear only when it is defined.
